// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte streams.
// A byte without req_last locks the grant to its channel until the packet ends or times out.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int LOCK_TIMEOUT = 1_000_000
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 locked,
    output logic                 lock_timeout_evt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, START, SETTLE, WAIT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_ch;
    logic [IDX_W-1:0]   pick;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic               accept;
    logic               tmo_run;
    logic               tmo_hit;
    logic [CNT_W-1:0]   tmo_cnt;

    assign elig = locked ? (req_valid & (NUM_REQ'(1) << lock_ch)) : req_valid;

    // First eligible channel at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && elig[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign accept    = nrst && (state == IDLE) && !tx_busy && found;
    assign req_ready = accept ? (NUM_REQ'(1) << pick) : '0;
    assign tmo_run   = (LOCK_TIMEOUT != 0) && locked && (state == IDLE) && !req_valid[lock_ch];
    assign tmo_hit   = tmo_run && (tmo_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SETTLE skips one cycle so uart_tx has time to raise tx_busy.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   state_nxt = SETTLE;
            SETTLE:  state_nxt = WAIT;
            WAIT:    if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_data          <= '0;
            tx_start         <= 1'b0;
            grant_id         <= '0;
            locked           <= 1'b0;
            lock_ch          <= '0;
            lock_timeout_evt <= 1'b0;
            rr_ptr           <= '0;
            tmo_cnt          <= '0;
        end else begin
            tx_start         <= accept;
            lock_timeout_evt <= 1'b0;
            if (accept) begin
                tx_data  <= req_data[{pick, 3'b000} +: 8];
                grant_id <= 3'(pick);
                rr_ptr   <= (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
                locked   <= !req_last[pick];
                if (!req_last[pick]) begin
                    lock_ch <= pick;
                end
                tmo_cnt  <= '0;
            end else if (tmo_hit) begin
                locked           <= 1'b0;
                lock_timeout_evt <= 1'b1;
                tmo_cnt          <= '0;
            end else if (tmo_run) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queue-driven requesters, a uart_tx busy model,
// and a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 3;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [2:0]     grant_id;
    logic           locked;
    logic           lock_timeout_evt;

    logic uart_busy  = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy = uart_busy | force_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int frame_len = 3;
    bit rand_frame = 1'b0;

    logic [8:0]  src_q[N][$];
    logic [11:0] exp_q[$];

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .locked(locked), .lock_timeout_evt(lock_timeout_evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input logic last);
        src_q[ch].push_back({last, d});
        exp_q.push_back({3'(ch), last, d});
    endtask

    // Requesters: a byte leaves its queue only after the edge that accepted it.
    initial begin
        logic [N-1:0] accm;
        logic [8:0]   b;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            accm = nrst ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (accm[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    req_valid[i] = 1'b1;
                    req_last[i]  = b[8];
                    req_data[8*i +: 8] = b[7:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // uart_tx model: busy rises the cycle after tx_start and lasts one frame.
    initial begin
        int rem;
        bit st;
        rem = 0;
        forever begin
            @(negedge clk);
            st = tx_start;
            @(posedge clk);
            #1;
            if (!nrst) rem = 0;
            else if (st) rem = rand_frame ? int'($urandom_range(1, 6)) : frame_len;
            if (rem > 0) begin
                uart_busy = 1'b1;
                rem--;
            end else begin
                uart_busy = 1'b0;
            end
        end
    end

    // Monitor: protocol checks and scoreboard pop on every tx_start.
    initial begin
        int          last_rdy;
        bit          prev_start;
        logic [11:0] e;
        last_rdy   = -100;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                last_rdy   = -100;
                prev_start = 1'b0;
            end else begin
                if (req_ready != '0) begin
                    chk("ready_onehot", $countones(req_ready), 1);
                    chk("ready_while_busy", tx_busy, 0);
                    chk("ready_spacing", (cyc - last_rdy) >= 4, 1);
                    last_rdy = cyc;
                end
                if (tx_start) begin
                    chk("start_width", prev_start, 0);
                    chk("start_after_ready", cyc - last_rdy, 1);
                    chk("start_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("tx_data", tx_data, e[7:0]);
                        chk("grant_id", grant_id, e[11:9]);
                        chk("locked_during_pkt", locked, !e[8]);
                    end
                end
                prev_start = tx_start;
            end
        end
    end

    task automatic rst_assert();
        #2 nrst = 1'b0;
        #1;
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_locked", locked, 0);
        chk("rst_evt", lock_timeout_evt, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        force_busy = 1'b0;
    endtask

    task automatic rst_release();
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst_assert();
        rst_release();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        n = 0;
        while (tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy_low", tx_busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Reference: whole packets leave in round-robin order of channels holding data.
    task automatic random_round();
        logic [8:0] mq[N][$];
        logic [8:0] b;
        int total, ptr, c, np, len;
        total = 0;
        for (int ch = 0; ch < N; ch++) begin
            np = int'($urandom_range(0, 3));
            for (int p = 0; p < np; p++) begin
                len = int'($urandom_range(1, 3));
                for (int j = 0; j < len; j++) begin
                    b = {(j == len - 1), 8'($urandom)};
                    mq[ch].push_back(b);
                    src_q[ch].push_back(b);
                    total++;
                end
            end
        end
        ptr = 0;
        while (total > 0) begin
            c = -1;
            for (int k = 0; k < N; k++) begin
                if (c < 0 && mq[(ptr + k) % N].size() > 0) c = (ptr + k) % N;
            end
            do begin
                b = mq[c].pop_front();
                exp_q.push_back({3'(c), b});
                total--;
            end while (!b[8]);
            ptr = (c + 1) % N;
        end
        wait_drain(3000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n, fall, evt_cyc;
        bit hi, lk_before;

        do_reset();

        // single byte on ch1
        frame_len = 3;
        send(1, 8'h41, 1'b1);
        wait_drain(200);
        chk("single_grant_id", grant_id, 1);
        chk("single_locked", locked, 0);
        chk("single_tx_data_hold", tx_data, 8'h41);

        // round robin across all channels
        do_reset();
        for (int r = 0; r < 2; r++) begin
            send(0, 8'hA0, 1'b1);
            send(1, 8'hB1, 1'b1);
            send(2, 8'hC2, 1'b1);
        end
        wait_drain(500);

        // packet lock on ch2 while ch0 waits
        do_reset();
        send(2, 8'h10, 1'b0);
        send(2, 8'h11, 1'b0);
        send(2, 8'h12, 1'b1);
        n = 0;
        while (!req_ready[2] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lock_first_grant", req_ready[2], 1);
        send(0, 8'h5A, 1'b1);
        wait_drain(500);

        // lock timeout
        do_reset();
        frame_len = 4;
        send(1, 8'h77, 1'b0);
        n = 0;
        while (!req_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_first_grant", req_ready[1], 1);
        send(0, 8'h5A, 1'b1);
        n = 0; hi = 1'b0; fall = -1;
        while (fall < 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (tx_busy) hi = 1'b1;
            else if (hi) fall = cyc;
        end
        chk("tmo_busy_fall_seen", fall >= 0, 1);
        n = 0; lk_before = 1'b0;
        @(negedge clk);
        while (!lock_timeout_evt && n < 100) begin
            lk_before = locked;
            @(negedge clk);
            n++;
        end
        evt_cyc = cyc;
        chk("tmo_evt_cycle", evt_cyc, fall + 1 + TMO);
        chk("tmo_locked_before", lk_before, 1);
        chk("tmo_locked_clear", locked, 0);
        chk("tmo_ch0_ready", req_ready, 3'b001);
        @(negedge clk);
        chk("tmo_evt_pulse", lock_timeout_evt, 0);
        wait_drain(300);

        // tx_busy held high externally
        do_reset();
        frame_len = 3;
        force_busy = 1'b1;
        send(0, 8'h3C, 1'b1);
        hi = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready != '0 || tx_start) hi = 1'b1;
        end
        chk("busy_hold_quiet", hi, 0);
        @(posedge clk);
        #1 force_busy = 1'b0;
        @(negedge clk);
        chk("grant_after_busy", req_ready, 3'b001);
        wait_drain(200);

        // reset in WAIT drops the grant and restarts round robin at ch0
        do_reset();
        frame_len = 6;
        send(0, 8'hD0, 1'b1);
        send(1, 8'hD1, 1'b1);
        send(2, 8'hD2, 1'b1);
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_start_seen", tx_start, 1);
        repeat (2) @(posedge clk);
        rst_assert();
        send(0, 8'hE0, 1'b1);
        send(1, 8'hE1, 1'b1);
        send(2, 8'hE2, 1'b1);
        rst_release();
        wait_drain(500);

        // randomized packets against the reference model
        rand_frame = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            random_round();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
